ntt_phase_sequencer: RTL and testbench

- Top-level scheduler for the mixed-radix 512-point NTT/INTT datapath.
- Takes one start request with a transform direction and drives the 4-bit conf code of the index/control FSM through its compute and drain phases.
- Waits on the FSM's done_flag and on fixed pipeline-drain intervals, then reports completion.
- Includes a watchdog that traps a compute phase that never terminates.

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/ntt_drain_timer.sv | 15 +
 rtl/ntt_phase_sequencer.sv | 85 ++++++++
 tb/tb_ntt_phase_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: conf codes, done_flag codes and sequencer state encoding shared by the NTT scheduler.
package ntt_pkg;
  localparam logic [3:0] CONF_IDLE         = 4'b0000;
  localparam logic [3:0] CONF_R2_NTT       = 4'b0001;
  localparam logic [3:0] CONF_R4_NTT       = 4'b0010;
  localparam logic [3:0] CONF_DONE_R2_NTT  = 4'b0011;
  localparam logic [3:0] CONF_DONE_R4_NTT  = 4'b0100;
  localparam logic [3:0] CONF_R4_INTT      = 4'b0101;
  localparam logic [3:0] CONF_R2_INTT      = 4'b0110;
  localparam logic [3:0] CONF_DONE_R2_INTT = 4'b0111;
  localparam logic [3:0] CONF_DONE_R4_INTT = 4'b1000;
  localparam logic [2:0] DF_R2 = 3'b001;
  localparam logic [2:0] DF_R4 = 3'b010;
  typedef enum logic [2:0] {S_IDLE, S_R2, S_R2_DRN, S_R4, S_R4_DRN, S_FIN, S_ERR} seq_state_t;
  function automatic logic [3:0] conf_of(input seq_state_t s, input logic m);
    case (s)
      S_R2:     conf_of = m ? CONF_R2_INTT : CONF_R2_NTT;
      S_R2_DRN: conf_of = m ? CONF_DONE_R2_INTT : CONF_DONE_R2_NTT;
      S_R4:     conf_of = m ? CONF_R4_INTT : CONF_R4_NTT;
      S_R4_DRN: conf_of = m ? CONF_DONE_R4_INTT : CONF_DONE_R4_NTT;
      default:  conf_of = CONF_IDLE;
    endcase
  endfunction
  function automatic logic [1:0] phase_of(input seq_state_t s);
    return (s == S_R2 || s == S_R2_DRN) ? 2'd1 :
           (s == S_R4 || s == S_R4_DRN) ? 2'd2 :
           (s == S_FIN || s == S_ERR)   ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/ntt_drain_timer.sv
// ntt_drain_timer: loadable 5-bit down-counter that parks at zero and flags it.
module ntt_drain_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [4:0] i_val,
  output logic       o_zero
);
  logic [4:0] r_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
  assign o_zero = r_cnt == 5'd0;
endmodule

// File: rtl/ntt_phase_sequencer.sv
// ntt_phase_sequencer: walks the index FSM through radix-2/radix-4 compute and drain phases
// for one NTT or INTT, with a per-phase watchdog.
module ntt_phase_sequencer
  import ntt_pkg::*;
#(
  parameter int DRAIN_R2 = 8,
  parameter int DRAIN_R4 = 14,
  parameter int WDOG_MAX = 1023,
  parameter int CNT_W    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic [2:0] done_flag,
  output logic [3:0] conf,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] phase
);
  seq_state_t       r_state, w_next;
  logic             r_mode, w_mode;
  logic [CNT_W-1:0] r_wdog;
  logic             w_compute, w_zero, w_wdog_hit;
  logic [3:0]       r_conf;
  logic             r_busy, r_done, r_err;
  logic [1:0]       r_phase;
  assign w_compute  = r_state == S_R2 || r_state == S_R4;
  assign w_wdog_hit = r_wdog == CNT_W'(WDOG_MAX);
  // The timer is held at the drain length throughout compute, so it starts counting on drain entry.
  ntt_drain_timer u_drain (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_compute),
    .i_val  (r_state == S_R2 ? 5'(DRAIN_R2 - 1) : 5'(DRAIN_R4 - 1)),
    .o_zero (w_zero)
  );
  always_comb begin
    w_next = r_state;
    w_mode = r_mode;
    case (r_state)
      S_IDLE, S_ERR: if (start) begin
        w_mode = mode;
        w_next = mode ? S_R4 : S_R2;
      end
      S_R2:     w_next = |(done_flag & DF_R2) ? S_R2_DRN : w_wdog_hit ? S_ERR : S_R2;
      S_R4:     w_next = |(done_flag & DF_R4) ? S_R4_DRN : w_wdog_hit ? S_ERR : S_R4;
      S_R2_DRN: w_next = !w_zero ? S_R2_DRN : r_mode ? S_FIN : S_R4;
      S_R4_DRN: w_next = !w_zero ? S_R4_DRN : r_mode ? S_R2 : S_FIN;
      default:  w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next = S_IDLE;
      w_mode = r_mode;
    end
  end
  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_wdog  <= '0;
      r_conf  <= CONF_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_phase <= 2'd0;
    end else begin
      r_state <= w_next;
      r_mode  <= w_mode;
      r_wdog  <= (w_compute && w_next == r_state) ? r_wdog + 1'b1 : '0;
      r_conf  <= conf_of(w_next, w_mode);
      r_busy  <= w_next inside {S_R2, S_R2_DRN, S_R4, S_R4_DRN};
      r_done  <= w_next == S_FIN;
      r_err   <= w_next == S_ERR;
      r_phase <= phase_of(w_next);
    end
  assign conf  = r_conf;
  assign busy  = r_busy;
  assign done  = r_done;
  assign err   = r_err;
  assign phase = r_phase;
endmodule

// File: tb/tb_ntt_phase_sequencer.sv
// tb_ntt_phase_sequencer: randomized runs against a timeline model of conf/busy/done/err/phase.
module tb_ntt_phase_sequencer;
  logic       clk = 1'b0;
  logic       rst, start, mode, abort;
  logic [2:0] done_flag;
  logic [3:0] conf;
  logic       busy, done, err;
  logic [1:0] phase;
  int         n_err = 0, n_chk = 0;
  logic [8:0] exp_q[$];
  logic [2:0] df_q[$];
  logic       st_q[$];
  wire  [8:0] outs = {conf, busy, done, err, phase};

  ntt_phase_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .done_flag(done_flag), .conf(conf), .busy(busy), .done(done), .err(err), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] v(input logic [3:0] c, input logic b, input logic d,
                                   input logic e, input logic [1:0] p);
    return {c, b, d, e, p};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got conf/b/d/e/ph=%b required=%b", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One phase of n cycles; the stub raises fin_df in its last cycle, noise never hits the matching bit.
  function automatic void seg(input logic [3:0] c, input logic [1:0] p, input int n,
                              input logic [2:0] fin_df, input logic [2:0] mask, input bit noise);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v(c, 1'b1, 1'b0, 1'b0, p));
      df_q.push_back((i == n - 1 && fin_df != 3'b000) ? fin_df : noise ? (3'($urandom) & mask) : 3'b000);
      st_q.push_back(noise && $urandom_range(0, 5) == 0);
    end
  endfunction

  task automatic run(input logic m, input int l1, input int l2, input bit noise, input int abort_at);
    logic [3:0] ca, da, cb, db;
    logic [1:0] pa, pb;
    logic [2:0] fa, fb;
    int         na, nb;
    exp_q.delete(); df_q.delete(); st_q.delete();
    ca = m ? 4'b0101 : 4'b0001; da = m ? 4'b1000 : 4'b0011; pa = m ? 2'd2 : 2'd1;
    fa = m ? 3'b010 : 3'b001;   na = m ? 14 : 8;
    cb = m ? 4'b0110 : 4'b0010; db = m ? 4'b0111 : 4'b0100; pb = m ? 2'd1 : 2'd2;
    fb = m ? 3'b001 : 3'b010;   nb = m ? 8 : 14;
    seg(ca, pa, l1, fa, ~fa, noise);
    seg(da, pa, na, 3'b000, 3'b111, noise);
    seg(cb, pb, l2, fb, ~fb, noise);
    seg(db, pb, nb, 3'b000, 3'b111, noise);
    exp_q.push_back(v(4'b0000, 1'b0, 1'b1, 1'b0, 2'd3));
    df_q.push_back(noise ? 3'($urandom) : 3'b000);
    st_q.push_back(1'b0);
    repeat (2) begin
      exp_q.push_back(9'd0); df_q.push_back(3'b000); st_q.push_back(1'b0);
    end
    start = 1'b1; mode = m;
    tick();
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("run m=%0d j=%0d", m, j), outs, exp_q[j]);
      if (j == abort_at) begin
        abort = 1'b1; done_flag = 3'b000;
        tick();
        abort = 1'b0;
        check("abort_next", outs, 9'd0);
        tick();
        check("abort_idle", outs, 9'd0);
        return;
      end
      done_flag = df_q[j]; start = st_q[j]; mode = 1'($urandom);
      tick();
    end
    done_flag = 3'b000; start = 1'b0;
  endtask

  task automatic wdog(input bit restart, input logic mr);
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0;
    for (int j = 0; j < 1024; j++) begin
      check($sformatf("wdog_r2 j=%0d", j), outs, v(4'b0001, 1'b1, 1'b0, 1'b0, 2'd1));
      done_flag = 3'($urandom) & 3'b110;
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      check("wdog_err", outs, v(4'b0000, 1'b0, 1'b0, 1'b1, 2'd3));
      done_flag = 3'($urandom);
      tick();
    end
    done_flag = 3'b000;
    if (restart) begin
      start = 1'b1; mode = mr;
      tick();
      start = 1'b0;
      check("err_restart", outs, mr ? v(4'b0101, 1'b1, 1'b0, 1'b0, 2'd2) : v(4'b0001, 1'b1, 1'b0, 1'b0, 2'd1));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wdog_abort", outs, 9'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; done_flag = 3'b000;
    repeat (2) tick();
    check("reset", outs, 9'd0);
    rst = 1'b0;
    tick();
    check("idle", outs, 9'd0);
    run(1'b0, 128, 512, 1'b0, -1);
    run(1'b1, 128, 512, 1'b0, -1);
    run(1'b0, 1024, 5, 1'b0, -1);
    wdog(1'b1, 1'b0);
    wdog(1'b1, 1'b1);
    wdog(1'b0, 1'b0);
    run(1'b0, 10, 10, 1'b1, 14);
    for (int k = 0; k < 20; k++)
      run(1'($urandom), $urandom_range(1, 40), $urandom_range(1, 40), 1'b1, -1);
    start = 1'b1; mode = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      check("pre_rst_r4", outs, v(4'b0101, 1'b1, 1'b0, 1'b0, 2'd2));
      tick();
    end
    #2 rst = 1'b1;
    #1 check("rst_async", outs, 9'd0);
    tick();
    rst = 1'b0;
    check("rst_held", outs, 9'd0);
    tick();
    check("rst_idle", outs, 9'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
